dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer that shares the single data memory (word-addressed array with `sel`/`byte_addr` sub-word access and write on rising `clk`) between the CPU load/store unit (port 0) and a DMA/debug loader (port 1). Ownership is granted per burst with a bounded beat count. Each port gets registered read data with a valid pulse. Misaligned accesses are flagged rather than sent to memory.

## Interface
- `MAX_BURST`, default 4: beats an owner may issue before yielding to a pending competitor; valid range 1–15.
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0`, `req1` in 1: beat request, held until granted.
- `we0`, `we1` in 1: 1 = store, 0 = load.
- `addr0`, `addr1` in 32: byte address.
- `wdata0`, `wdata1` in 32: store data, right-justified.
- `size0`, `size1` in 2: 00 word, 01 half, 10 byte, 11 bit.
- `lock0`, `lock1` in 1: owner keeps grant past `MAX_BURST`.
- `gnt0`, `gnt1` out 1: beat accepted this cycle (combinational).
- `rvalid0`, `rvalid1` out 1: one-cycle pulse, completion of the previous-cycle beat.
- `rdata0`, `rdata1` out 32: registered load data, 0 for stores or errors.
- `err0`, `err1` out 1: registered with `rvalid`; misaligned beat.
- `mem_we` out 1: to memory `MemWrite`.
- `mem_addr` out 30: `addr[31:2]` of owner.
- `mem_wdata` out 32: owner `wdata`.
- `mem_sel` out 2: owner `size`.
- `mem_byte_addr` out 2: owner `addr[1:0]`.
- `mem_rdata` in 32: combinational memory read data.

## Operation
- FSM states: IDLE, OWN0, OWN1. A 1-bit `last` register holds the last owner.
- IDLE: no grants.
  - Only one `reqN` high → OWNN next cycle.
  - Both high → arbitration winner (see Configuration).
  - Neither → stay IDLE.
- OWNN:
  - `gntN = reqN`. The other port's `gnt` is 0.
  - Mux drives `mem_*` from port N regardless. `mem_we = gntN & weN & ~misaligned`.
- Beat counter `cnt`:
  - Cleared on entry to any OWN state.
  - Increments on each granted beat, saturating at `MAX_BURST`.
- Leaving OWNN:
  - `reqN` low → IDLE next cycle.
  - Else `cnt` reaching `MAX_BURST` at this edge, other `req` high, and `lockN` low → IDLE next cycle.
  - Else stay.
  - `last` ← N when leaving OWNN.
- Misaligned: half with `addr[0]=1`, or word with `addr[1:0]≠0`. Byte and bit are never misaligned.
  - Beat is still granted and counted.
  - No write is issued.
  - Next cycle: `rvalid=1`, `err=1`, `rdata=0`.
- Load beat: `rdataN ← mem_rdata` at the grant edge, with `rvalidN` high the following cycle. Store beat: `rvalidN` pulses with `rdata=0`.
- Outputs on `rst` asserted (asynchronous):
  - State IDLE, `last=1`, `cnt=0`.
  - All `gnt`, `rvalid`, `err`, `mem_we` = 0; `rdata0`/`rdata1` = 0.
  - A beat in flight is dropped with no `rvalid`. `mem_we` drops immediately, so no partial write occurs.

## Timing
- From IDLE: `req` → `gnt` takes 1 cycle. Back-to-back beats inside a burst run at 1 per cycle.
- Grant → `rvalid` takes 1 cycle, fixed for loads, stores and errors.
- Ownership handoff costs exactly one IDLE bubble cycle.
- `req` dropped for one cycle ends the burst. Re-requesting then re-arbitrates.
- Simultaneous: the owner's final limited beat and the competitor's `req` in the same cycle → the beat completes, then IDLE, then the competitor wins if the configured policy selects it.
- With `lock` held, the burst is unbounded. The competitor starves until `lock` or `req` drops.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin. On a tie in IDLE, the port ≠ `last` wins. After reset, port 0 wins the first tie.
- Undefined: fixed priority. Port 0 always wins a tie in IDLE; `last` is still maintained but unused for arbitration.
- Burst limit and lock behave identically in both builds.

## Test plan
- Reset, then port 0 `lw` at `addr0=0x4` with memory word 1 = `0x0ba00007` → `gnt0` in cycle 2; `rvalid0=1`, `rdata0=0x0ba00007` in cycle 3.
- Port 1 `sb`, `wdata1=0xAB`, `addr1=0x9`, then port 1 `lw` at `0x8` → memory word 2 = `0x0cAB000C`; `mem_sel=10`, `mem_byte_addr=01` on the store beat.
- Both request continuously, `MAX_BURST=4`, RR build → alternating bursts of exactly 4 beats per port with one IDLE cycle between. Fixed build: port 1 receives nothing while port 0 keeps `req0` high only through re-arbitration losses.
- Port 0 `lock0=1` with 10 beats while `req1` high → 10 consecutive `gnt0`; `gnt1` only after `lock0` and `req0` fall.
- Port 0 `sh` to `addr0=0x3` → `mem_we` stays 0, memory unchanged; next cycle `rvalid0=1`, `err0=1`, `rdata0=0`.
- `rst` pulsed mid-burst during a store beat → `mem_we` 0 immediately, no `rvalid`, FSM IDLE; the first tie afterward goes to port 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the CPU load/store unit (port 0)
// and a DMA/debug loader (port 1). Ownership is granted per burst with a bounded
// beat count. Each port receives registered read data with a one-cycle valid
// pulse. Misaligned beats are flagged with err and never reach memory.
//
// Build option: define DMEM_ARB_RR_EN for round-robin tie-breaking in IDLE.
// When it is undefined, port 0 always wins a tie.
module dmem_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [1:0]  size0,
    input  logic [1:0]  size1,
    input  logic        lock0,
    input  logic        lock1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_sel,
    output logic [1:0]  mem_byte_addr,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    logic [1:0]  state_reg, state_next;
    logic        last_reg, last_next;
    logic [3:0]  cnt_reg, cnt_next;

    // Per-port request bundles, indexed by port number.
    logic [1:0]  req, we, lock, gnt, mis;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [1:0]  size  [2];

    logic        own;
    logic        beat;
    logic [4:0]  cnt_inc;
    logic        burst_done;
    logic        tie_pick1;

    assign req      = {req1, req0};
    assign we       = {we1, we0};
    assign lock     = {lock1, lock0};
    assign addr[0]  = addr0;
    assign addr[1]  = addr1;
    assign wdata[0] = wdata0;
    assign wdata[1] = wdata1;
    assign size[0]  = size0;
    assign size[1]  = size1;

    // Current owner index; IDLE presents port 0 on the bus with no write.
    assign own = (state_reg == OWN1);

    assign gnt[0] = (state_reg == OWN0) & req[0];
    assign gnt[1] = (state_reg == OWN1) & req[1];
    assign gnt0   = gnt[0];
    assign gnt1   = gnt[1];
    assign beat   = |gnt;

    // Memory bus mux: driven from the owner whether or not it is requesting.
    assign mem_addr      = addr[own][31:2];
    assign mem_wdata     = wdata[own];
    assign mem_sel       = size[own];
    assign mem_byte_addr = addr[own][1:0];
    assign mem_we        = beat & we[own] & ~mis[own];

    // The beat being granted now is the last one allowed in a contested burst.
    assign cnt_inc    = {1'b0, cnt_reg} + 5'd1;
    assign burst_done = beat & (cnt_inc >= {1'b0, BURST_MAX});

`ifdef DMEM_ARB_RR_EN
    // Round-robin: the port that did not own last wins a tie.
    assign tie_pick1 = ~last_reg;
`else
    // Fixed priority: port 0 wins every tie.
    assign tie_pick1 = 1'b0;
`endif

    // Next-state, burst counter and last-owner logic.
    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = 4'd0;
                if (req[0] && req[1]) begin
                    state_next = tie_pick1 ? OWN1 : OWN0;
                end else if (req[0]) begin
                    state_next = OWN0;
                end else if (req[1]) begin
                    state_next = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (beat) begin
                    cnt_next = burst_done ? BURST_MAX : cnt_inc[3:0];
                end
                if (!req[own]) begin
                    state_next = IDLE;
                    last_next  = own;
                end else if (burst_done && req[~own] && !lock[own]) begin
                    state_next = IDLE;
                    last_next  = own;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Per-port alignment check and completion registers.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic        rvalid_reg;
            logic        err_reg;
            logic [31:0] rdata_reg;

            assign mis[gi] = ((size[gi] == 2'b00) && (addr[gi][1:0] != 2'b00)) ||
                             ((size[gi] == 2'b01) && addr[gi][0]);

            // Capture the completion of a granted beat: load data, or 0 for stores and errors.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rvalid_reg <= 1'b0;
                    err_reg    <= 1'b0;
                    rdata_reg  <= 32'd0;
                end else begin
                    rvalid_reg <= gnt[gi];
                    err_reg    <= gnt[gi] & mis[gi];
                    if (gnt[gi]) begin
                        rdata_reg <= (we[gi] | mis[gi]) ? 32'd0 : mem_rdata;
                    end
                end
            end
        end
    endgenerate

    assign rvalid0 = g_port[0].rvalid_reg;
    assign rvalid1 = g_port[1].rvalid_reg;
    assign err0    = g_port[0].err_reg;
    assign err1    = g_port[1].err_reg;
    assign rdata0  = g_port[0].rdata_reg;
    assign rdata1  = g_port[1].rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed beats with a scoreboard of expected
// completions per port, checked by a monitor on every rvalid pulse.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic [1:0]  size0 = 0, size1 = 0;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we;
    logic [31:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [29:0] mem_addr;
    logic [1:0]  mem_sel, mem_byte_addr;

    logic [31:0] mem [16];

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t mon0, mon1;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .size0(size0), .size1(size1), .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_sel(mem_sel), .mem_byte_addr(mem_byte_addr), .mem_rdata(mem_rdata)
    );

    // Data memory model: full-word read, sub-word write with byte 0 in bits 31:24.
    assign mem_rdata = (mem_addr < 30'd16) ? mem[mem_addr[3:0]] : 32'd0;

    always @(posedge clk) begin
        if (mem_we && mem_addr < 30'd16) begin
            case (mem_sel)
                2'b00: mem[mem_addr[3:0]] <= mem_wdata;
                2'b01: begin
                    if (mem_byte_addr[1]) mem[mem_addr[3:0]][15:0]  <= mem_wdata[15:0];
                    else                  mem[mem_addr[3:0]][31:16] <= mem_wdata[15:0];
                end
                2'b10: begin
                    case (mem_byte_addr)
                        2'd0: mem[mem_addr[3:0]][31:24] <= mem_wdata[7:0];
                        2'd1: mem[mem_addr[3:0]][23:16] <= mem_wdata[7:0];
                        2'd2: mem[mem_addr[3:0]][15:8]  <= mem_wdata[7:0];
                        default: mem[mem_addr[3:0]][7:0] <= mem_wdata[7:0];
                    endcase
                end
                default: mem[mem_addr[3:0]][31 - 8 * int'(mem_byte_addr)] <= mem_wdata[0];
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rvalid pops the oldest expected completion for that port.
    always @(negedge clk) begin
        if (rvalid0) begin
            if (q0.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL rvalid0_unexpected: got rvalid0=1 expected no completion");
            end else begin
                mon0 = q0.pop_front();
                chk("rdata0", rdata0, mon0.rdata);
                chk("err0", 32'(err0), 32'(mon0.err));
                $display("port0 completion rdata=%h err=%0d", rdata0, err0);
            end
        end
        if (rvalid1) begin
            if (q1.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL rvalid1_unexpected: got rvalid1=1 expected no completion");
            end else begin
                mon1 = q1.pop_front();
                chk("rdata1", rdata1, mon1.rdata);
                chk("err1", 32'(err1), 32'(mon1.err));
                $display("port1 completion rdata=%h err=%0d", rdata1, err1);
            end
        end
    end

    task automatic set_port(input int p, input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [1:0] s, input logic l);
        if (p == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d; size0 = s; lock0 = l;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d; size1 = s; lock1 = l;
        end
    endtask

    // One beat on port p; returns the bus state seen in the grant cycle and the
    // number of cycles spent waiting before the grant.
    task automatic single(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] s, input logic [31:0] exp_rd, input logic exp_err,
                          output logic mwe, output logic [1:0] msel, output logic [1:0] mba,
                          output int waited);
        exp_t e;
        logic g;
        e.rdata = exp_rd;
        e.err   = exp_err;
        if (p == 0) q0.push_back(e); else q1.push_back(e);
        set_port(p, 1'b1, w, a, d, s, 1'b0);
        waited = 0;
        mwe = 0; msel = 0; mba = 0;
        g = 1'b0;
        while (!g && waited < 16) begin
            @(negedge clk);
            g = (p == 0) ? gnt0 : gnt1;
            if (g) begin
                mwe = mem_we; msel = mem_sel; mba = mem_byte_addr;
            end else begin
                waited++;
            end
        end
        if (!g) begin
            n_checks++; n_err++;
            $display("FAIL grant_timeout port%0d: got no gnt expected gnt within 16 cycles", p);
        end
        $display("beat port%0d we=%0d addr=%h size=%0d waited=%0d", p, w, a, s, waited);
        @(posedge clk); #1;
        set_port(p, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Expected grant in the continuous-tie scenario (cycle 0 is the IDLE cycle).
    function automatic logic tie_exp(input int port, input int c);
        int owner;
        if (c % 5 == 0) return 1'b0;
`ifdef DMEM_ARB_RR_EN
        owner = (c / 5) % 2;
`else
        owner = 0;
`endif
        return (owner == port);
    endfunction

    initial begin
        logic       mwe;
        logic [1:0] msel, mba;
        int         waited;
        exp_t       e;
        logic       e0, e1;
        bit         g;
        int         n;

        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        mem[0] = 32'h11223344;
        mem[1] = 32'h0ba00007;
        mem[2] = 32'h0c00000C;

        // Reset state.
        #2;
        chk("rst_gnt0", 32'(gnt0), 0);
        chk("rst_gnt1", 32'(gnt1), 0);
        chk("rst_rvalid0", 32'(rvalid0), 0);
        chk("rst_rvalid1", 32'(rvalid1), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Port 0 lw from 0x4: one cycle to grant.
        single(0, 1'b0, 32'h4, 32'h0, 2'b00, 32'h0ba00007, 1'b0, mwe, msel, mba, waited);
        chk("lw_gnt_latency", 32'(waited), 1);
        chk("lw_mem_we", 32'(mwe), 0);

        // Port 1 sb 0xAB to 0x9, then lw from 0x8.
        single(1, 1'b1, 32'h9, 32'hAB, 2'b10, 32'h0, 1'b0, mwe, msel, mba, waited);
        chk("sb_mem_we", 32'(mwe), 1);
        chk("sb_mem_sel", 32'(msel), 32'h2);
        chk("sb_mem_byte_addr", 32'(mba), 32'h1);
        chk("sb_mem_word2", mem[2], 32'h0cAB000C);
        single(1, 1'b0, 32'h8, 32'h0, 2'b00, 32'h0cAB000C, 1'b0, mwe, msel, mba, waited);

        // Port 0 sh to 0x3: misaligned, no write, error completion.
        single(0, 1'b1, 32'h3, 32'h1234, 2'b01, 32'h0, 1'b1, mwe, msel, mba, waited);
        chk("mis_mem_we", 32'(mwe), 0);
        chk("mis_mem_word0", mem[0], 32'h11223344);

        // Locked burst of 10 beats on port 0 while port 1 waits.
        set_port(0, 1'b1, 1'b0, 32'h4, 32'h0, 2'b00, 1'b1);
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            e0 = (c >= 1 && c <= 10);
            e1 = (c == 13);
            chk($sformatf("lock_gnt0_c%0d", c), 32'(gnt0), 32'(e0));
            chk($sformatf("lock_gnt1_c%0d", c), 32'(gnt1), 32'(e1));
            $display("lock cycle %0d gnt0=%0d gnt1=%0d", c, gnt0, gnt1);
            if (e0) begin e.rdata = 32'h0ba00007; e.err = 1'b0; q0.push_back(e); end
            if (e1) begin e.rdata = 32'h0cAB000C; e.err = 1'b0; q1.push_back(e); end
            @(posedge clk); #1;
            if (c == 0)  set_port(1, 1'b1, 1'b0, 32'h8, 32'h0, 2'b00, 1'b0);
            if (c == 10) set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
            if (c == 13) set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-burst: first store completes, second store is killed.
        e.rdata = 32'h0; e.err = 1'b0; q0.push_back(e);
        set_port(0, 1'b1, 1'b1, 32'h14, 32'h55AA55AA, 2'b00, 1'b0);
        g = 1'b0; n = 0;
        while (!g && n < 16) begin
            @(negedge clk);
            g = gnt0;
            n++;
        end
        chk("rstmid_first_gnt", 32'(g), 1);
        @(posedge clk); #1;
        addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
        @(negedge clk);
        chk("rstmid_second_gnt", 32'(gnt0), 1);
        chk("rstmid_second_we", 32'(mem_we), 1);
        #1;
        rst = 1'b1;
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        #1;
        chk("rstmid_mem_we", 32'(mem_we), 0);
        chk("rstmid_gnt0", 32'(gnt0), 0);
        chk("rstmid_rvalid0", 32'(rvalid0), 0);
        $display("reset asserted mid-burst mem_we=%0d gnt0=%0d", mem_we, gnt0);
        @(negedge clk);
        chk("rstmid_rvalid0_next", 32'(rvalid0), 0);
        rst = 1'b0;
        chk("rstmid_word4", mem[4], 32'h0);
        chk("rstmid_word5", mem[5], 32'h55AA55AA);
        @(posedge clk); #1;

        // Both ports request continuously; first tie after reset goes to port 0.
        set_port(0, 1'b1, 1'b0, 32'h4, 32'h0, 2'b00, 1'b0);
        set_port(1, 1'b1, 1'b0, 32'h8, 32'h0, 2'b00, 1'b0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            e0 = tie_exp(0, c);
            e1 = tie_exp(1, c);
            chk($sformatf("tie_gnt0_c%0d", c), 32'(gnt0), 32'(e0));
            chk($sformatf("tie_gnt1_c%0d", c), 32'(gnt1), 32'(e1));
            $display("tie cycle %0d gnt0=%0d gnt1=%0d", c, gnt0, gnt1);
            if (e0) begin e.rdata = 32'h0ba00007; e.err = 1'b0; q0.push_back(e); end
            if (e1) begin e.rdata = 32'h0cAB000C; e.err = 1'b0; q1.push_back(e); end
            @(posedge clk); #1;
        end
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        chk("q0_drained", 32'(q0.size()), 0);
        chk("q1_drained", 32'(q1.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
